// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: Funct codes, FSM states,
// and the HI/LO instruction decode helper.
package muldiv_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX
    } state_t;

    function automatic logic is_hilo_funct(input logic [5:0] f);
        case (f)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO,
            F_MULT, F_MULTU, F_DIV, F_DIVU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final sign correction: turns unsigned magnitude results into signed HI/LO values,
// including the divide-by-zero result override.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             is_div,
    input  logic             neg_main,
    input  logic             neg_rem,
    input  logic             div_zero,
    input  logic [WIDTH-1:0] mag_hi,
    input  logic [WIDTH-1:0] mag_lo,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        prod_neg = -{mag_hi, mag_lo};
        hi_out   = mag_hi;
        lo_out   = mag_lo;
        if (is_div) begin
            // Quotient of a divide by zero is all ones regardless of operand signs.
            if (div_zero)
                lo_out = '1;
            else if (neg_main)
                lo_out = -mag_lo;
            if (neg_rem)
                hi_out = -mag_hi;
        end else if (neg_main) begin
            hi_out = prod_neg[2*WIDTH-1:WIDTH];
            lo_out = prod_neg[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide sequencer with architectural HI/LO registers;
// stalls later HI/LO instructions while an operation is in flight.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t state, state_n;

    logic [CNT_W-1:0] cnt;
    logic             op_div, neg_main, neg_rem, div_zero;
    logic [WIDTH-1:0] opb, acc_hi, acc_lo;

    logic             hilo_op, accept, start_md, is_signed;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    always_comb begin
        hilo_op   = in_valid & is_hilo_funct(Funct);
        stall     = hilo_op & busy;
        accept    = hilo_op & ~busy;
        // Funct bit 3 separates mult/div (0x18-0x1b) from the move ops (0x10-0x13).
        start_md  = accept & Funct[3];
        is_signed = ~Funct[0];
        rs_mag    = (is_signed & rs_data[WIDTH-1]) ? -rs_data : rs_data;
        rt_mag    = (is_signed & rt_data[WIDTH-1]) ? -rt_data : rt_data;
    end

    always_comb begin
        // Shift-add multiply: {acc_hi, acc_lo} shifts right, multiplier bits consumed from acc_lo[0].
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        // Restoring divide: remainder in acc_hi, dividend shifting out / quotient shifting into acc_lo.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_diff  = div_shift[WIDTH-1:0] - opb;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start_md) state_n = S_ITER;
            S_ITER:  if (cnt == CNT_W'(WIDTH - 1)) state_n = S_FIX;
            S_FIX:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            op_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            opb      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start_md) begin
                        busy     <= 1'b1;
                        op_div   <= Funct[1];
                        neg_main <= is_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        neg_rem  <= is_signed & Funct[1] & rs_data[WIDTH-1];
                        div_zero <= Funct[1] & (rt_data == '0);
                        acc_hi   <= '0;
                        if (Funct[1]) begin
                            acc_lo <= rs_mag;
                            opb    <= rt_mag;
                        end else begin
                            acc_lo <= rt_mag;
                            opb    <= rs_mag;
                        end
                    end else if (accept && Funct == F_MTHI) begin
                        hi <= rs_data;
                    end else if (accept && Funct == F_MTLO) begin
                        lo <= rs_data;
                    end
                end
                S_ITER: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op_div) begin
                        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                    busy <= 1'b0;
                    done <= 1'b1;
                    cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    muldiv_signfix #(
        .WIDTH(WIDTH)
    ) u_signfix (
        .is_div   (op_div),
        .neg_main (neg_main),
        .neg_rem  (neg_rem),
        .div_zero (div_zero),
        .mag_hi   (acc_hi),
        .mag_lo   (acc_lo),
        .hi_out   (fix_hi),
        .lo_out   (fix_lo)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table plus random ops checked through a result
// scoreboard, and hand sequences for stall, back-to-back, mthi and reset corners.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
    localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1a, DIVU = 6'h1b;

    logic          clk = 1'b0;
    logic          reset, in_valid;
    logic [5:0]    Funct;
    logic [W-1:0]  rs_data, rt_data;
    logic          busy, stall, done;
    logic [W-1:0]  hi, lo;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .Funct(Funct),
        .rs_data(rs_data), .rt_data(rt_data),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] hi; logic [W-1:0] lo; } exp_t;
    typedef struct { logic [5:0] f; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] eh; logic [W-1:0] el; } vec_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   done_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        logic signed [W-1:0] qa, qb;
        r.hi = '0;
        r.lo = '0;
        case (f)
            MULT: begin
                sa = {{32{a[W-1]}}, a};
                sb = {{32{b[W-1]}}, b};
                sp = sa * sb;
                r.hi = sp[63:32];
                r.lo = sp[31:0];
            end
            MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            DIV: begin
                if (b == 0) begin
                    r.lo = '1; r.hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.lo = a; r.hi = '0;
                end else begin
                    qa = a; qb = b;
                    r.lo = qa / qb;
                    r.hi = qa % qb;
                end
            end
            default: begin
                if (b == 0) begin
                    r.lo = '1; r.hi = a;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && done === 1'b1) begin
            done_seen++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                e = sbq.pop_front();
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
            end
        end
    end

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        in_valid = 1'b1; Funct = f; rs_data = a; rt_data = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic issue_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_t e;
        e.hi = eh; e.lo = el;
        sbq.push_back(e);
        issue(f, a, b);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy !== 1'b0 || sbq.size() != 0) && k < 80) begin
            @(negedge clk);
            k++;
        end
        if (k >= 80) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%b pending=%0d expected idle", busy, sbq.size());
            sbq.delete();
        end
    endtask

    vec_t vecs[11];
    logic [5:0] md_ops[4];

    initial begin
        int n, k, seen0;
        logic early;
        logic [W-1:0] ra, rb;
        logic [5:0] rf;
        exp_t e;

        vecs[0]  = '{MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{DIVU,  32'd7,          32'd0,         32'd7,         32'hFFFF_FFFF};
        vecs[4]  = '{DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        vecs[5]  = '{DIV,   32'hFFFF_FFF7,  32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF};
        vecs[6]  = '{MULT,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0};
        vecs[7]  = '{DIVU,  32'hFFFF_FFFF,  32'h10,        32'hF,         32'h0FFF_FFFF};
        vecs[8]  = '{DIV,   32'd100,        32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2};
        vecs[9]  = '{MULTU, 32'h1234_5678,  32'h10,        32'h1,         32'h2345_6780};
        vecs[10] = '{MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         32'h1};
        md_ops[0] = MULT; md_ops[1] = MULTU; md_ops[2] = DIV; md_ops[3] = DIVU;

        reset = 1'b1; in_valid = 1'b0; Funct = '0; rs_data = '0; rt_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);

        // Table-driven vectors through the scoreboard.
        for (int i = 0; i < 11; i++) begin
            issue_md(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);
            if (i == 0) begin
                Funct = MFLO; // squashed hilo slot while busy
                #1;
                check("squashed_no_stall", stall, 0);
                check("busy_after_accept", busy, 1);
            end
            wait_idle();
        end

        // mult 7 * -3 with mflo waiting behind it.
        sbq.push_back(model(MULT, 32'd7, 32'hFFFF_FFFD));
        @(negedge clk);
        in_valid = 1'b1; Funct = MULT; rs_data = 32'd7; rt_data = 32'hFFFF_FFFD;
        @(negedge clk);
        Funct = MFLO;
        seen0 = done_seen;
        n = 0;
        forever begin
            #1;
            if (!stall || n > 60) break;
            n++;
            @(negedge clk);
        end
        check("mflo_stall_cycles", n, W + 1);
        check("mflo_done_cycle", done, 1);
        check("mflo_reads_new", lo, 32'hFFFF_FFEB);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("done_single_pulse", done_seen - seen0, 1);
        wait_idle();

        // Back-to-back: new mult presented in the done cycle.
        issue_md(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        k = 0;
        while (done !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("b2b_done_seen", done, 1);
        e.hi = 32'h0; e.lo = 32'd30;
        sbq.push_back(e);
        in_valid = 1'b1; Funct = MULT; rs_data = 32'd5; rt_data = 32'd6;
        #1;
        check("b2b_no_stall", stall, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("b2b_accepted", busy, 1);
        wait_idle();

        // mthi while busy: stalls, no early write, then lands after the result.
        sbq.push_back(model(MULTU, 32'h0001_0000, 32'h0003_0000));
        @(negedge clk);
        in_valid = 1'b1; Funct = MULTU; rs_data = 32'h0001_0000; rt_data = 32'h0003_0000;
        @(negedge clk);
        Funct = MTHI; rs_data = 32'h1234;
        n = 0;
        early = 1'b0;
        forever begin
            #1;
            if (!stall || n > 60) break;
            n++;
            if (hi == 32'h1234) early = 1'b1;
            @(negedge clk);
        end
        check("mthi_stall_cycles", n, W + 1);
        check("mthi_no_early_write", early, 0);
        check("mthi_done_hi_result", hi, 32'h3);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("mthi_written", hi, 32'h1234);
        wait_idle();

        issue(MTLO, 32'hABCD, 32'h0);
        #1;
        check("mtlo_written", lo, 32'hABCD);

        // Non-hilo instructions flow while busy.
        issue_md(MULT, 32'd2, 32'd3, 32'd0, 32'd6);
        in_valid = 1'b1; Funct = 6'h20;
        #1;
        check("nonhilo_no_stall", stall, 0);
        Funct = MFHI;
        #1;
        check("mfhi_busy_stall", stall, 1);
        in_valid = 1'b0;
        wait_idle();

        // Reset in ITER cycle 10 drops the operation.
        issue_md(MULT, 32'd9, 32'd9, 32'd0, 32'd81);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sbq.delete();
        seen0 = done_seen;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_hi", hi, 0);
        check("midreset_lo", lo, 0);
        check("midreset_done", done, 0);
        repeat (40) @(negedge clk);
        check("midreset_no_done", done_seen - seen0, 0);
        issue_md(MULT, 32'd9, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'hFFFF_FFAF);
        wait_idle();

        // Random operations against the reference model.
        for (int i = 0; i < 12; i++) begin
            rf = md_ops[$urandom_range(0, 3)];
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 2) rb = $urandom_range(1, 15);
            if (i % 4 == 3) rb = '0;
            if (i == 5) ra = '0;
            sbq.push_back(model(rf, ra, rb));
            issue(rf, ra, rb);
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
